pipeline_host_elastic: RTL and testbench



---
 rtl/pipeline_host_pkg.sv | 48 ++++
 rtl/pipeline_host_stage.sv | 69 ++++++
 rtl/pipeline_host_elastic.sv | 124 ++++++++++++
 tb/tb_pipeline_host_elastic.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_host_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_host_pkg
// Brief    : Shared mode encoding, LFSR defaults and per-stage operation.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_host_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'b00,
        MODE_PASS    = 2'b01,
        MODE_XOR_IDX = 2'b10,
        MODE_ROL1    = 2'b11
    } mode_e;

    localparam int unsigned            C_LFSR_W    = 80;
    localparam logic [C_LFSR_W-1:0]    C_LFSR_SEED = 80'h123456789ABCDEF12345;
    localparam int unsigned            C_TAP_A     = 47;
    localparam int unsigned            C_TAP_B     = 15;

    // Widest datapath the stage op supports; narrower words are masked.
    localparam int unsigned            C_OP_MAX_W  = 64;

    function automatic logic [C_OP_MAX_W-1:0] stage_op(
        input logic [C_OP_MAX_W-1:0] din,
        input int unsigned           width,
        input mode_e                 op,
        input int unsigned           idx,
        input logic [C_OP_MAX_W-1:0] inc
    );
        logic [C_OP_MAX_W-1:0] mask;
        logic [C_OP_MAX_W-1:0] d;
        logic [C_OP_MAX_W-1:0] r;
        mask = (width >= C_OP_MAX_W) ? '1
             : ((C_OP_MAX_W'(1) << width) - C_OP_MAX_W'(1));
        d    = din & mask;
        case (op)
            MODE_ADD:     r = d + inc;
            MODE_PASS:    r = d;
            MODE_XOR_IDX: r = d ^ C_OP_MAX_W'(idx);
            MODE_ROL1:    r = (d << 1) | (d >> (width - 1));
            default:      r = d;
        endcase
        return r & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_host_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_host_stage
// Brief    : One elastic pipeline stage: data/valid flops, ready, stage op.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_host_stage
    import pipeline_host_pkg::*;
#(
    parameter int unsigned       DATA_W = 12,
    parameter int unsigned       IDX    = 0,
    parameter logic [DATA_W-1:0] INC    = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              pon_rst_n_i,
    input  logic              i_flush,
    input  logic [1:0]        i_mode,
    input  logic              i_up_valid,
    input  logic [DATA_W-1:0] i_up_data,
    input  logic              i_dn_ready,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_load;
    logic [DATA_W-1:0] w_next_data;

    assign o_ready = !r_valid || i_dn_ready;
    assign w_load  = i_up_valid && o_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // The head stage captures the input word as-is; later stages apply the op.
    if (IDX == 0) begin : g_raw
        logic w_unused_mode;
        assign w_unused_mode = ^i_mode;
        assign w_next_data   = i_up_data;
    end else begin : g_op
        logic [C_OP_MAX_W-1:0] w_op;
        assign w_op = stage_op(C_OP_MAX_W'(i_up_data), DATA_W, mode_e'(i_mode),
                               IDX, C_OP_MAX_W'(INC));
        assign w_next_data = w_op[DATA_W-1:0];
        if (DATA_W < C_OP_MAX_W) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_op[C_OP_MAX_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_load || (r_valid && !i_dn_ready);
            end
            if (w_load) begin
                r_data <= w_next_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_host_elastic.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_host_elastic
// Brief    : DEPTH-stage elastic datapath with LFSR/beat-counter program port.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_host_elastic
    import pipeline_host_pkg::*;
#(
    parameter int unsigned       DATA_W    = 12,
    parameter int unsigned       DEPTH     = 5,
    parameter logic [DATA_W-1:0] INC       = DATA_W'(1),
    parameter int unsigned       LFSR_W    = C_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED = C_LFSR_SEED,
    parameter int unsigned       TAP_A     = C_TAP_A,
    parameter int unsigned       TAP_B     = C_TAP_B,
    parameter int unsigned       DAT_W     = 14,
    parameter int unsigned       PC_W      = 13
) (
    input  logic                       clk,
    input  logic                       pon_rst_n_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic [1:0]                 mode,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [DAT_W-1:0]           prog_dat_o,
    output logic [PC_W-1:0]            pc_o,
    input  logic [PC_W-1:0]            prog_adr_i,
    output logic [PC_W-1:0]            prog_adr_out
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  w_valid;
    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_up_valid;
    logic [DEPTH-1:0]  w_dn_ready;
    logic [DATA_W-1:0] w_data    [DEPTH];
    logic [DATA_W-1:0] w_up_data [DEPTH];
    logic              w_accept;
    logic [OCC_W-1:0]  w_occ;

    logic [LFSR_W-1:0] r_lfsr;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_prog_adr;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            // Gating with flush keeps a flushed cycle from loading stage 0.
            assign w_up_valid[i] = in_valid && !flush;
            assign w_up_data[i]  = in_data;
        end else begin : g_body
            assign w_up_valid[i] = w_valid[i-1];
            assign w_up_data[i]  = w_data[i-1];
        end

        if (i == DEPTH - 1) begin : g_tail
            assign w_dn_ready[i] = out_ready;
        end else begin : g_link
            assign w_dn_ready[i] = w_ready[i+1];
        end

        pipeline_host_stage #(
            .DATA_W (DATA_W),
            .IDX    (i),
            .INC    (INC)
        ) u_stage (
            .clk         (clk),
            .pon_rst_n_i (pon_rst_n_i),
            .i_flush     (flush),
            .i_mode      (mode),
            .i_up_valid  (w_up_valid[i]),
            .i_up_data   (w_up_data[i]),
            .i_dn_ready  (w_dn_ready[i]),
            .o_ready     (w_ready[i]),
            .o_valid     (w_valid[i]),
            .o_data      (w_data[i])
        );
    end

    assign in_ready  = w_ready[0] && !flush;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end
    assign occupancy = w_occ;

    // Pattern generator and beat counter advance only on accepted input beats.
    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_lfsr <= LFSR_SEED;
            r_pc   <= '0;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0],
                       r_lfsr[LFSR_W-1] ^ r_lfsr[TAP_A] ^ r_lfsr[TAP_B]};
            r_pc   <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge pon_rst_n_i) begin
        if (!pon_rst_n_i) begin
            r_prog_adr <= '0;
        end else begin
            r_prog_adr <= prog_adr_i;
        end
    end

    assign prog_dat_o   = r_lfsr[DAT_W-1:0];
    assign pc_o         = r_pc;
    assign prog_adr_out = r_prog_adr;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_host_elastic.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_host_elastic
// Brief    : Scoreboard bench: input-side model pushes, output monitor pops.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_host_elastic;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 5;
    localparam int DAT_W  = 14;
    localparam int PC_W   = 13;
    localparam int LFSR_W = 80;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int TAP_A  = 47;
    localparam int TAP_B  = 15;
    localparam logic [LFSR_W-1:0] SEED = 80'h123456789ABCDEF12345;
    localparam logic [DATA_W-1:0] INC  = 12'd1;

    logic              clk = 1'b0;
    logic              pon_rst_n_i = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [1:0]        mode = 2'b00;
    logic [PC_W-1:0]   prog_adr_i = '0;

    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [DAT_W-1:0]  prog_dat_o;
    logic [PC_W-1:0]   pc_o;
    logic [PC_W-1:0]   prog_adr_out;

    always #5 clk = ~clk;

    pipeline_host_elastic dut (
        .clk          (clk),
        .pon_rst_n_i  (pon_rst_n_i),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .mode         (mode),
        .flush        (flush),
        .occupancy    (occupancy),
        .prog_dat_o   (prog_dat_o),
        .pc_o         (pc_o),
        .prog_adr_i   (prog_adr_i),
        .prog_adr_out (prog_adr_out)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [LFSR_W-1:0] m_lfsr = SEED;
    logic [PC_W-1:0]   m_pc = '0;
    logic [PC_W-1:0]   m_adr = '0;
    logic [DATA_W-1:0] last_out = '0;
    int                n_out = 0;
    logic              hs = 1'b0;
    logic              stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word that should emerge: the input pushed through stages 1..DEPTH-1.
    function automatic logic [DATA_W-1:0] model_out(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = d;
        for (int s = 1; s < DEPTH; s++) begin
            case (m)
                2'b00:   r = r + INC;
                2'b01:   r = r;
                2'b10:   r = r ^ DATA_W'(s);
                default: r = {r[DATA_W-2:0], r[DATA_W-1]};
            endcase
        end
        return r;
    endfunction

    // Input side: decide acceptance from the flow-control rules and push expectations.
    initial forever begin
        @(negedge clk);
        #1;
        if (pon_rst_n_i) begin
            m_adr = prog_adr_i;
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && (exp_q.size() < DEPTH || out_ready)) begin
                exp_q.push_back(model_out(in_data, mode));
                m_lfsr = {m_lfsr[LFSR_W-2:0], m_lfsr[LFSR_W-1] ^ m_lfsr[TAP_A] ^ m_lfsr[TAP_B]};
                m_pc   = m_pc + 1'b1;
            end
        end
    end

    // Output side: compare state and pop on every output handshake.
    initial forever begin
        @(negedge clk);
        if (pon_rst_n_i) begin
            chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
            chk("in_ready", 32'(in_ready),
                32'(!flush && (exp_q.size() < DEPTH || out_ready)));
            chk("prog_dat_o", 32'(prog_dat_o), 32'(m_lfsr[DAT_W-1:0]));
            chk("pc_o", 32'(pc_o), 32'(m_pc));
            chk("prog_adr_out", 32'(prog_adr_out), 32'(m_adr));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h expected no word", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    last_out = out_data;
                    n_out++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        hs    = in_valid && in_ready;
        stall = in_valid && !in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send1(input logic [DATA_W-1:0] d, input logic [1:0] m);
        mode      = m;
        out_ready = 1'b1;
        in_data   = d;
        in_valid  = 1'b1;
        step();
        idle(DEPTH + 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"},    32'(out_valid), 32'd0);
        chk({tag, "_occupancy"},    32'(occupancy), 32'd0);
        chk({tag, "_pc_o"},         32'(pc_o), 32'd0);
        chk({tag, "_prog_adr_out"}, 32'(prog_adr_out), 32'd0);
        chk({tag, "_out_data"},     32'(out_data), 32'd0);
        chk({tag, "_prog_dat_o"},   32'(prog_dat_o), 32'h2345);
        chk({tag, "_in_ready"},     32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int lat;
        int nxt;
        int base;
        int saw_stall;
        logic seen;
        logic [PC_W-1:0] pc_before;

        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        pon_rst_n_i = 1'b1;
        idle(2);

        // Single ADD beat: latency and value.
        mode      = 2'b00;
        out_ready = 1'b1;
        in_data   = 12'h100;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (seen) begin
            @(posedge clk);
            #1;
        end
        chk("latency", 32'(lat), 32'(DEPTH - 1));
        chk("add_out", 32'(last_out), 32'h104);
        chk("lfsr_after_1", 32'(prog_dat_o), 32'h068B);
        chk("pc_after_1", 32'(pc_o), 32'd1);
        idle(6);
        chk("lfsr_hold", 32'(prog_dat_o), 32'h068B);
        chk("pc_hold", 32'(pc_o), 32'd1);

        send1(12'h801, 2'b01);
        chk("mode_pass", 32'(last_out), 32'h801);
        send1(12'h801, 2'b11);
        chk("mode_rol1", 32'(last_out), 32'h018);
        send1(12'h801, 2'b10);
        chk("mode_xor_idx", 32'(last_out), 32'h805);

        // Backpressure: stream 1..8, downstream stalled for cycles 3..7.
        mode      = 2'b00;
        nxt       = 1;
        base      = n_out;
        saw_stall = 0;
        for (int c = 0; c < 60 && (nxt <= 8 || exp_q.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (nxt <= 8);
            in_data   = DATA_W'(nxt);
            step();
            if (hs) nxt++;
            if (stall) saw_stall++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_seen", 32'(saw_stall > 0), 32'd1);
        chk("bp_count", 32'(n_out - base), 32'd8);
        chk("bp_last", 32'(last_out), 32'h00C);
        idle(2);

        // Flush with three words in flight and a concurrent offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = DATA_W'($urandom);
            step();
        end
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        pc_before = m_pc;
        flush     = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_pc", 32'(pc_o), 32'(pc_before));
        out_ready = 1'b1;
        idle(DEPTH + 2);

        // Randomised traffic per mode; mode changes only once drained.
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            for (int k = 0; k < 250; k++) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                out_ready  = ($urandom_range(0, 2) != 0);
                flush      = ($urandom_range(0, 39) == 0);
                in_data    = DATA_W'($urandom);
                prog_adr_i = PC_W'($urandom);
                step();
            end
            out_ready = 1'b1;
            idle(DEPTH + 2);
        end

        prog_adr_i = 13'h1ABC;
        step();
        chk("prog_adr_1abc", 32'(prog_adr_out), 32'h1ABC);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data    = DATA_W'($urandom);
            prog_adr_i = PC_W'($urandom);
            step();
        end
        #2;
        pon_rst_n_i = 1'b0;
        #1;
        in_valid = 1'b0;
        check_reset_outputs("midreset");
        exp_q.delete();
        m_lfsr = SEED;
        m_pc   = '0;
        m_adr  = '0;
        @(posedge clk);
        #1;
        pon_rst_n_i = 1'b1;
        out_ready   = 1'b1;
        idle(2);

        // Counter wrap: 2^PC_W accepted beats from zero.
        in_valid = 1'b1;
        for (int k = 0; k < (1 << PC_W); k++) begin
            in_data = DATA_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("pc_wrap", 32'(pc_o), 32'd0);
        idle(DEPTH + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
